// File: rtl/sfr_mm_pkg.sv
// Shared types and helpers for the SFR bus masters.
package sfr_mm_pkg;

    // Master FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // $clog2 that never returns zero, so a width derived from it is always legal
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Page-select width for a given page count
    function automatic int page_width(input int page_num);
        return clog2_min1(page_num);
    endfunction

    // LSB position of channel idx inside a packed per-channel bus of field width w
    function automatic int slice_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/sfr_rr_arbiter.sv
// Round-robin arbiter: the channel after the last winner has the highest priority.
module sfr_rr_arbiter
    import sfr_mm_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int IW = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [IW-1:0]     grant_idx,
    output logic              grant_valid
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand_idx;
    int            cand;

    // Scan from the priority pointer and pick the first requesting channel
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand     = (int'(ptr_q) + i) % NUM_CH;
            cand_idx = IW'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid     = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

    // Move priority to the channel after the winner when a grant is consumed
    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sfr_mm_arbiter.sv
// Multi-channel SFR bus master: round-robin arbitration onto one paged SFR bus
// with ack timeout and per-channel single-cycle completion pulse.
module sfr_mm_arbiter
    import sfr_mm_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PAGE_NUM   = 4,
    parameter int NUM_CH     = 4,
    parameter int TIMEOUT    = 255,
    localparam int PW = page_width(PAGE_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_CH*PW-1:0]         req_page,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDR_WIDTH-1:0]        sfraddr,
    output logic                         sfrwe,
    output logic                         sfroe,
    output logic [DATA_WIDTH-1:0]        sfrdatao,
    output logic [PW-1:0]                sfr_page_sel,
    input  logic                         sfrack,
    input  logic [DATA_WIDTH-1:0]        sfrdatai,
    output logic                         busy,
    output logic                         stray_ack
);

    localparam int IW = clog2_min1(NUM_CH);
    localparam int CW = clog2_min1(TIMEOUT + 1);

    // Per-channel views of the packed request buses
    logic [ADDR_WIDTH-1:0] ch_addr  [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_wdata [NUM_CH];
    logic [PW-1:0]         ch_page  [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_addr[gi]  = req_addr[slice_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH];
        assign ch_wdata[gi] = req_wdata[slice_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
        assign ch_page[gi]  = req_page[slice_lsb(gi, PW) +: PW];
    end

    state_e                state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] sfraddr_q, sfraddr_d;
    logic [DATA_WIDTH-1:0] sfrdatao_q, sfrdatao_d;
    logic [PW-1:0]         page_q, page_d;
    logic                  sfrwe_q, sfrwe_d;
    logic                  sfroe_q, sfroe_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_CH-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  stray_q, stray_d;

    logic [NUM_CH-1:0]     arb_grant;
    logic [IW-1:0]         arb_idx;
    logic                  arb_valid;
    logic                  in_idle;
    logic                  expired;

    assign in_idle = (state_q == ST_IDLE);

    sfr_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .advance     (in_idle),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Expiry fires on the edge that closes the TIMEOUT-th strobe cycle
    assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    // Next-state logic for the IDLE -> ACCESS -> RESP transaction sequence
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sfraddr_d   = sfraddr_q;
        sfrdatao_d  = sfrdatao_q;
        page_d      = page_q;
        sfrwe_d     = sfrwe_q;
        sfroe_d     = sfroe_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        stray_d     = stray_q | (sfrack & ~sfrwe_q & ~sfroe_q);
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d    = ST_ACCESS;
                    grant_d    = arb_idx;
                    sfraddr_d  = ch_addr[arb_idx];
                    sfrdatao_d = ch_wdata[arb_idx];
                    page_d     = ch_page[arb_idx];
                    sfrwe_d    = req_we[arb_idx];
                    sfroe_d    = ~req_we[arb_idx];
                    cnt_d      = '0;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // An ack arriving together with expiry takes precedence
                if (sfrack) begin
                    state_d              = ST_RESP;
                    sfrwe_d              = 1'b0;
                    sfroe_d              = 1'b0;
                    rsp_rdata_d          = sfrwe_q ? '0 : sfrdatai;
                    rsp_err_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                end else if (expired) begin
                    state_d              = ST_RESP;
                    sfrwe_d              = 1'b0;
                    sfroe_d              = 1'b0;
                    rsp_rdata_d          = '1;
                    rsp_err_d            = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus registers; reset drops strobes immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            sfraddr_q   <= '0;
            sfrdatao_q  <= '0;
            page_q      <= '0;
            sfrwe_q     <= 1'b0;
            sfroe_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sfraddr_q   <= sfraddr_d;
            sfrdatao_q  <= sfrdatao_d;
            page_q      <= page_d;
            sfrwe_q     <= sfrwe_d;
            sfroe_q     <= sfroe_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            stray_q     <= stray_d;
        end
    end

    assign req_ready    = in_idle ? arb_grant : '0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign sfraddr      = sfraddr_q;
    assign sfrwe        = sfrwe_q;
    assign sfroe        = sfroe_q;
    assign sfrdatao     = sfrdatao_q;
    assign sfr_page_sel = page_q;
    assign busy         = ~in_idle;
    assign stray_ack    = stray_q;

endmodule

// File: tb/tb_sfr_mm_arbiter.sv
// Self-checking bench for sfr_mm_arbiter: directed scenarios plus a randomized
// run, all checked against a transaction-level round-robin/timeout model.
module tb_sfr_mm_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam int PWB = 2;
    localparam int TO  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    req_we;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH*PWB-1:0] req_page;
    logic [NCH-1:0]    rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     sfraddr;
    logic              sfrwe;
    logic              sfroe;
    logic [DW-1:0]     sfrdatao;
    logic [PWB-1:0]    sfr_page_sel;
    logic              sfrack;
    logic [DW-1:0]     sfrdatai;
    logic              busy;
    logic              stray_ack;

    always #5 clk = ~clk;

    sfr_mm_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PAGE_NUM   (4),
        .NUM_CH     (NCH),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_page     (req_page),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .sfraddr      (sfraddr),
        .sfrwe        (sfrwe),
        .sfroe        (sfroe),
        .sfrdatao     (sfrdatao),
        .sfr_page_sel (sfr_page_sel),
        .sfrack       (sfrack),
        .sfrdatai     (sfrdatai),
        .busy         (busy),
        .stray_ack    (stray_ack)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model state: next highest-priority channel
    int rr_ptr = 0;

    logic [AW-1:0]  ch_addr  [NCH];
    logic [DW-1:0]  ch_wdata [NCH];
    logic [PWB-1:0] ch_page  [NCH];
    logic           ch_we    [NCH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NCH-1:0] mask);
        for (int i = 0; i < NCH; i++) begin
            if (mask[(rr_ptr + i) % NCH]) return (rr_ptr + i) % NCH;
        end
        return -1;
    endfunction

    task automatic drive_reqs(input logic [NCH-1:0] mask);
        req_valid = mask;
        for (int c = 0; c < NCH; c++) begin
            req_addr[c*AW +: AW]    = ch_addr[c];
            req_wdata[c*DW +: DW]   = ch_wdata[c];
            req_page[c*PWB +: PWB]  = ch_page[c];
            req_we[c]               = ch_we[c];
        end
    endtask

    // One full transaction from IDLE; ack_after = strobe cycle on which the
    // slave acks (0 = never), rd = data returned with the ack.
    task automatic run_txn(input string tag, input logic [NCH-1:0] mask,
                           input int ack_after, input logic [DW-1:0] rd, input bit drop);
        int win;
        int n;
        int exp_cycles;
        bit exp_err;
        logic [DW-1:0] exp_rd;
        bit done;
        win = model_pick(mask);
        drive_reqs(mask);
        #1;
        check({tag, ":ready"}, 64'(req_ready), 64'(1) << win);
        @(posedge clk); #1;
        rr_ptr = (win + 1) % NCH;
        if (drop) req_valid = '0;
        exp_err    = (ack_after == 0) || (ack_after > TO);
        exp_cycles = exp_err ? TO : ack_after;
        exp_rd     = exp_err ? 8'hFF : (ch_we[win] ? 8'h00 : rd);
        check({tag, ":strobe"}, 64'({sfrwe, sfroe}), ch_we[win] ? 64'h2 : 64'h1);
        check({tag, ":addr"}, 64'(sfraddr), 64'(ch_addr[win]));
        check({tag, ":page"}, 64'(sfr_page_sel), 64'(ch_page[win]));
        if (ch_we[win]) check({tag, ":wdata"}, 64'(sfrdatao), 64'(ch_wdata[win]));
        check({tag, ":ready_busy"}, 64'(req_ready), 64'h0);
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            if (sfrwe || sfroe) begin
                n++;
                if (n == ack_after) begin
                    sfrack   = 1'b1;
                    sfrdatai = rd;
                end
                @(posedge clk); #1;
                sfrack   = 1'b0;
                sfrdatai = DW'($urandom);
            end else begin
                done = 1'b1;
            end
        end
        check({tag, ":cycles"}, 64'(n), 64'(exp_cycles));
        check({tag, ":rsp_valid"}, 64'(rsp_valid), 64'(1) << win);
        check({tag, ":rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        check({tag, ":rsp_err"}, 64'(rsp_err), 64'(exp_err));
        @(posedge clk); #1;
        check({tag, ":rsp_done"}, 64'({rsp_valid, busy}), 64'h0);
        check({tag, ":addr_hold"}, 64'(sfraddr), 64'(ch_addr[win]));
        $display("txn %s: ch%0d we=%0d addr=%h ack_after=%0d strobe=%0d err=%0d rdata=%h",
                 tag, win, ch_we[win], ch_addr[win], ack_after, n, rsp_err, rsp_rdata);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_page  = '0;
        sfrack    = 1'b0;
        sfrdatai  = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_addr[c] = AW'(16'h0100 * c);
            ch_wdata[c] = DW'(8'h10 + c);
            ch_page[c] = PWB'(c);
            ch_we[c] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst:req_ready", 64'(req_ready), 64'h0);
        check("rst:rsp", 64'({rsp_valid, rsp_rdata, rsp_err}), 64'h0);
        check("rst:bus", 64'({sfraddr, sfrwe, sfroe, sfrdatao, sfr_page_sel}), 64'h0);
        check("rst:busy_stray", 64'({busy, stray_ack}), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All channels valid continuously: 0,1,2,3,0
        for (int k = 0; k < 5; k++) run_txn("rr", 4'b1111, 1, DW'(8'h30 + k), 1'b0);
        req_valid = '0;

        // Single read on ch2, acked on strobe cycle 2
        ch_addr[2] = 16'h0040; ch_page[2] = 2'd1; ch_we[2] = 1'b0;
        run_txn("rd_ch2", 4'b0100, 2, 8'hA5, 1'b1);

        // Write on ch0 never acked: full timeout
        ch_addr[0] = 16'h1234; ch_wdata[0] = 8'h5A; ch_we[0] = 1'b1;
        run_txn("wr_timeout", 4'b0001, 0, 8'h00, 1'b1);

        // Ack on exactly the expiry cycle wins over the timeout
        ch_we[3] = 1'b0; ch_addr[3] = 16'hBEEF;
        run_txn("ack_at_to", 4'b1000, TO, 8'h3C, 1'b1);

        // Reset during ACCESS on ch1
        ch_we[1] = 1'b0;
        drive_reqs(4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        check("rstmid:active", 64'({busy, sfroe}), 64'h3);
        #2 rst = 1'b1;
        #1;
        check("rstmid:strobes", 64'({sfrwe, sfroe, busy, rsp_valid}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rr_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rstmid:no_rsp", 64'(rsp_valid), 64'h0);
        end
        run_txn("after_rst", 4'b1111, 1, 8'h77, 1'b0);
        req_valid = '0;

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            logic [NCH-1:0] mask;
            int ack;
            mask = NCH'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++) begin
                ch_addr[c]  = AW'($urandom);
                ch_wdata[c] = DW'($urandom);
                ch_page[c]  = PWB'($urandom);
                ch_we[c]    = 1'($urandom);
            end
            ack = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10));
            run_txn("rand", mask, ack, DW'($urandom), 1'b0);
        end
        req_valid = '0;
        @(posedge clk); #1;
        check("stray:clear", 64'(stray_ack), 64'h0);

        // Stray ack while idle is sticky until reset
        sfrack = 1'b1;
        @(posedge clk); #1;
        sfrack = 1'b0;
        check("stray:set", 64'(stray_ack), 64'h1);
        run_txn("stray_txn", 4'b0100, 3, 8'h99, 1'b1);
        check("stray:hold", 64'(stray_ack), 64'h1);
        rst = 1'b1;
        #1;
        check("stray:rst", 64'(stray_ack), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so a stuck DUT still ends the run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
